// File: rtl/m68k_bus_ctrl.sv
// m68k_bus_ctrl: 68000 bus controller. Decodes address windows into one-hot
// registered chip selects, inserts per-region wait states before DTACK,
// raises BERR after a timeout on unmapped accesses, and muxes read data back.
//
// Handshake: an access starts when IDLE samples AS low with at least one data
// strobe low (cycle 0). DTACK/BERR are held low until the CPU releases AS;
// the release is answered by dropping cs/DTACK/BERR on the next edge, and one
// IDLE cycle always follows before the next access can be sampled.
module m68k_bus_ctrl #(
    parameter int NUM_REGIONS = 3,
    parameter int ADDR_WIDTH  = 23,
    parameter int DATA_WIDTH  = 16,
    parameter int WAIT_WIDTH  = 4,
    parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE =
        {23'h001000, 23'h000800, 23'h000000},
    parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_MASK = {3{23'h007800}},
    parameter logic [NUM_REGIONS*WAIT_WIDTH-1:0] REGION_WAIT = {4'd3, 4'd1, 4'd0},
    parameter int TIMEOUT     = 63
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [ADDR_WIDTH-1:0]           cpu_addr,
    input  logic                            cpu_as_n,
    input  logic                            cpu_uds_n,
    input  logic                            cpu_lds_n,
    input  logic                            cpu_rw,
    input  logic [NUM_REGIONS*DATA_WIDTH-1:0] dev_dout,
    output logic [NUM_REGIONS-1:0]          cs,
    output logic [DATA_WIDTH-1:0]           cpu_din,
    output logic                            dtack_n,
    output logic                            berr_n
);

    localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam int CNT_W = (WAIT_WIDTH > 8) ? WAIT_WIDTH : 8;

    typedef enum logic [2:0] {
        S_RELEASE = 3'd0,
        S_IDLE    = 3'd1,
        S_WAIT    = 3'd2,
        S_ACK     = 3'd3,
        S_TMO     = 3'd4,
        S_ERR     = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   hit_q, hit_d;
    logic [NUM_REGIONS-1:0] cs_q, cs_d;
    logic                   dtack_q, dtack_d;
    logic                   berr_q, berr_d;

    logic                   hit;
    logic [IDX_W-1:0]       hit_idx;
    logic [WAIT_WIDTH-1:0]  hit_wait;
    logic                   strobe;

    // Direction is routed to the devices outside this block.
    logic unused_rw;
    assign unused_rw = cpu_rw;

    assign strobe = !cpu_as_n && (!cpu_uds_n || !cpu_lds_n);

    // Address decode: scan high to low so the lowest matching region wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if ((cpu_addr & REGION_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                (REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] & REGION_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
        hit_wait = REGION_WAIT[hit_idx*WAIT_WIDTH +: WAIT_WIDTH];
    end

    // State and output registers; reset parks in RELEASE to drop any cycle in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RELEASE;
            cnt_q   <= '0;
            idx_q   <= '0;
            hit_q   <= 1'b0;
            cs_q    <= '0;
            dtack_q <= 1'b1;
            berr_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            hit_q   <= hit_d;
            cs_q    <= cs_d;
            dtack_q <= dtack_d;
            berr_q  <= berr_d;
        end
    end

    // Next-state and next-output logic; AS release always takes priority over counting.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        hit_d   = hit_q;
        cs_d    = cs_q;
        dtack_d = dtack_q;
        berr_d  = berr_q;
        case (state_q)
            S_RELEASE: begin
                if (cpu_as_n) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (strobe) begin
                    idx_d = hit_idx;
                    hit_d = hit;
                    if (hit) begin
                        cs_d          = '0;
                        cs_d[hit_idx] = 1'b1;
                        cnt_d         = CNT_W'(hit_wait);
                        if (hit_wait == '0) begin
                            state_d = S_ACK;
                            dtack_d = 1'b0;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end else begin
                        cnt_d   = CNT_W'(TIMEOUT);
                        state_d = S_TMO;
                    end
                end
            end
            S_WAIT: begin
                if (cpu_as_n) begin
                    cs_d    = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    dtack_d = 1'b0;
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_ACK: begin
                if (cpu_as_n) begin
                    cs_d    = '0;
                    dtack_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_TMO: begin
                if (cpu_as_n) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    berr_d  = 1'b0;
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_ERR: begin
                if (cpu_as_n) begin
                    berr_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_RELEASE;
                cs_d    = '0;
                dtack_d = 1'b1;
                berr_d  = 1'b1;
            end
        endcase
    end

    assign cs      = cs_q;
    assign dtack_n = dtack_q;
    assign berr_n  = berr_q;
    assign cpu_din = hit_q ? dev_dout[idx_q*DATA_WIDTH +: DATA_WIDTH] : {DATA_WIDTH{1'b1}};

endmodule

// File: tb/tb_m68k_bus_ctrl.sv
// tb_m68k_bus_ctrl: directed bench for m68k_bus_ctrl. Cycle n of an access is
// observed #1 after the n-th rising edge following the strobe set-up.
module tb_m68k_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [22:0] cpu_addr;
    logic        cpu_as_n, cpu_uds_n, cpu_lds_n, cpu_rw;
    logic [47:0] dev_dout;
    logic [2:0]  cs, cs_ov;
    logic [15:0] cpu_din, cpu_din_ov;
    logic        dtack_n, berr_n, dtack_n_ov, berr_n_ov;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    m68k_bus_ctrl dut (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_as_n(cpu_as_n),
        .cpu_uds_n(cpu_uds_n), .cpu_lds_n(cpu_lds_n), .cpu_rw(cpu_rw),
        .dev_dout(dev_dout), .cs(cs), .cpu_din(cpu_din),
        .dtack_n(dtack_n), .berr_n(berr_n)
    );

    // Second instance with regions 0 and 1 both based at 0 to check priority.
    m68k_bus_ctrl #(
        .REGION_BASE({23'h001000, 23'h000000, 23'h000000})
    ) dut_ov (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_as_n(cpu_as_n),
        .cpu_uds_n(cpu_uds_n), .cpu_lds_n(cpu_lds_n), .cpu_rw(cpu_rw),
        .dev_dout(dev_dout), .cs(cs_ov), .cpu_din(cpu_din_ov),
        .dtack_n(dtack_n_ov), .berr_n(berr_n_ov)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [22:0] a, input logic uds, input logic lds, input logic rw);
        cpu_addr  = a;
        cpu_uds_n = uds;
        cpu_lds_n = lds;
        cpu_rw    = rw;
        cpu_as_n  = 1'b0;
    endtask

    task automatic release_bus();
        cpu_as_n  = 1'b1;
        cpu_uds_n = 1'b1;
        cpu_lds_n = 1'b1;
    endtask

    initial begin
        rst       = 1'b1;
        cpu_addr  = '0;
        cpu_as_n  = 1'b1;
        cpu_uds_n = 1'b1;
        cpu_lds_n = 1'b1;
        cpu_rw    = 1'b1;
        dev_dout  = {16'hC0DE, 16'h1234, 16'hBEEF};
        tick(2);
        chk("rst_cs", 32'(cs), 32'h0);
        chk("rst_dtack", 32'(dtack_n), 32'h1);
        chk("rst_berr", 32'(berr_n), 32'h1);
        chk("rst_din", 32'(cpu_din), 32'hFFFF);
        rst = 1'b0;
        tick(1);   // RELEASE -> IDLE with AS high

        // Region 0 word read, zero wait states.
        start(23'h000010, 1'b0, 1'b0, 1'b1);
        tick(1);
        chk("t1_cs_c1", 32'(cs), 32'h1);
        chk("t1_dtack_c1", 32'(dtack_n), 32'h0);
        chk("t1_din", 32'(cpu_din), 32'hBEEF);
        tick(1);
        chk("t1_dtack_hold", 32'(dtack_n), 32'h0);
        release_bus();
        tick(1);
        chk("t1_cs_rel", 32'(cs), 32'h0);
        chk("t1_dtack_rel", 32'(dtack_n), 32'h1);

        // Back-to-back: region 2 write, lower strobe only, three wait states.
        start(23'h001004, 1'b1, 1'b0, 1'b0);
        tick(1);
        chk("t2_cs_c1", 32'(cs), 32'h4);
        chk("t2_dtack_c1", 32'(dtack_n), 32'h1);
        tick(1);
        chk("t2_dtack_c2", 32'(dtack_n), 32'h1);
        tick(1);
        chk("t2_dtack_c3", 32'(dtack_n), 32'h1);
        tick(1);
        chk("t2_dtack_c4", 32'(dtack_n), 32'h0);
        chk("t2_cs_c4", 32'(cs), 32'h4);
        chk("t2_din", 32'(cpu_din), 32'hC0DE);
        release_bus();
        tick(1);
        chk("t2_cs_rel", 32'(cs), 32'h0);
        chk("t2_dtack_rel", 32'(dtack_n), 32'h1);

        // Unmapped read times out into BERR at cycle 64.
        start(23'h004000, 1'b0, 1'b0, 1'b1);
        tick(1);
        chk("t3_cs_c1", 32'(cs), 32'h0);
        chk("t3_din", 32'(cpu_din), 32'hFFFF);
        tick(62);
        chk("t3_berr_c63", 32'(berr_n), 32'h1);
        tick(1);
        chk("t3_berr_c64", 32'(berr_n), 32'h0);
        chk("t3_dtack_c64", 32'(dtack_n), 32'h1);
        release_bus();
        tick(1);
        chk("t3_berr_rel", 32'(berr_n), 32'h1);

        // Overlapping regions: lowest index wins.
        start(23'h000000, 1'b0, 1'b0, 1'b1);
        tick(1);
        chk("t4_cs", 32'(cs), 32'h1);
        chk("t4_cs_ov", 32'(cs_ov), 32'h1);
        chk("t4_dtack_ov", 32'(dtack_n_ov), 32'h0);
        release_bus();
        tick(1);
        chk("t4_cs_ov_rel", 32'(cs_ov), 32'h0);

        // Abort of a region 2 access at cycle 2, then a region 1 access.
        start(23'h001000, 1'b0, 1'b0, 1'b1);
        tick(2);
        chk("t5_cs_c2", 32'(cs), 32'h4);
        release_bus();
        tick(1);
        chk("t5_cs_c3", 32'(cs), 32'h0);
        chk("t5_dtack_c3", 32'(dtack_n), 32'h1);
        tick(3);
        chk("t5_dtack_late", 32'(dtack_n), 32'h1);
        start(23'h000800, 1'b0, 1'b1, 1'b1);
        tick(1);
        chk("t5b_cs_c1", 32'(cs), 32'h2);
        chk("t5b_dtack_c1", 32'(dtack_n), 32'h1);
        tick(1);
        chk("t5b_dtack_c2", 32'(dtack_n), 32'h0);
        chk("t5b_din", 32'(cpu_din), 32'h1234);
        release_bus();
        tick(1);
        chk("t5b_dtack_rel", 32'(dtack_n), 32'h1);

        // AS without a data strobe does not start an access.
        start(23'h000010, 1'b1, 1'b1, 1'b1);
        tick(2);
        chk("ds_none_cs", 32'(cs), 32'h0);
        cpu_uds_n = 1'b0;
        tick(1);
        chk("ds_late_cs", 32'(cs), 32'h1);
        release_bus();
        tick(1);

        // Reset mid-access with AS still low.
        start(23'h001000, 1'b0, 1'b0, 1'b1);
        tick(2);
        chk("t6_cs_c2", 32'(cs), 32'h4);
        rst = 1'b1;
        tick(1);
        chk("t6_cs_rst", 32'(cs), 32'h0);
        chk("t6_dtack_rst", 32'(dtack_n), 32'h1);
        chk("t6_berr_rst", 32'(berr_n), 32'h1);
        chk("t6_din_rst", 32'(cpu_din), 32'hFFFF);
        rst = 1'b0;
        tick(5);
        chk("t6_cs_held", 32'(cs), 32'h0);
        chk("t6_dtack_held", 32'(dtack_n), 32'h1);
        release_bus();
        tick(1);
        start(23'h000010, 1'b0, 1'b0, 1'b1);
        tick(1);
        chk("t6_new_cs", 32'(cs), 32'h1);
        chk("t6_new_dtack", 32'(dtack_n), 32'h0);
        release_bus();
        tick(1);
        chk("t6_new_rel", 32'(dtack_n), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/m68k_bus_ctrl.md
Name: m68k_bus_ctrl

Overview:
Parametrised 68000 bus controller that replaces the fixed always-ready DTACK and hard-wired chip selects in the SoC top level. It decodes NUM_REGIONS address windows from parameters and drives one registered chip select per region. Each region has its own wait-state count before DTACK. Accesses that hit no region raise BERR after a timeout. It sits between the fx68k bus pins and the ROM, RAM and peripheral blocks, and muxes read data back to the CPU.

Parameters:
NUM_REGIONS, 3, number of decoded regions (1..8)
ADDR_WIDTH, 23, width of the CPU word address (address bits [23:1])
DATA_WIDTH, 16, data bus width
WAIT_WIDTH, 4, width of each per-region wait-state field
REGION_BASE, {23'h001000,23'h000800,23'h000000}, flattened NUM_REGIONS*ADDR_WIDTH word-address bases; region 0 sits in the LSBs
REGION_MASK, {3{23'h007800}}, flattened compare masks, same packing
REGION_WAIT, {4'd3,4'd1,4'd0}, flattened wait-state counts, same packing
TIMEOUT, 63, cycles before BERR on an unmapped access (1..255)

Ports:
clk  in  1  system clock; the only clock
rst  in  1  synchronous reset, active-high
cpu_addr  in  ADDR_WIDTH  CPU word address (eab)
cpu_as_n  in  1  address strobe, active low
cpu_uds_n  in  1  upper data strobe, active low
cpu_lds_n  in  1  lower data strobe, active low
cpu_rw  in  1  1 = read, 0 = write
dev_dout  in  NUM_REGIONS*DATA_WIDTH  read data per region; region 0 in the LSBs
cs  out  NUM_REGIONS  registered one-hot chip selects
cpu_din  out  DATA_WIDTH  read data to the CPU
dtack_n  out  1  data transfer acknowledge, active low
berr_n  out  1  bus error, active low

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Hit rule: region i hits when (cpu_addr & MASK_i) == (BASE_i & MASK_i).
- Overlapping hits: the lowest index wins. cs is always one-hot or zero.
- Strobe rule: a bus cycle starts when the FSM is in IDLE and samples cpu_as_n=0 together with (cpu_uds_n=0 or cpu_lds_n=0). Call this sample edge cycle 0.
- Reset values: state=RELEASE, cs=0, dtack_n=1, berr_n=1, counter=0, latched region index=none.
- States:
  - RELEASE: wait for cpu_as_n=1, then go to IDLE. This drops any cycle already in flight when reset releases.
  - IDLE: on the strobe rule, latch the hit index and the hit flag.
    - Hit: set cs[idx]=1 from cycle 1 and load counter=REGION_WAIT[idx]. Go to ACK if the wait is 0, otherwise go to WAIT.
    - Miss: load counter=TIMEOUT and go to TMO.
  - WAIT: decrement the counter each cycle. Go to ACK when the counter reaches 1.
  - ACK: dtack_n=0, cs held. Stay until cpu_as_n=1, then set cs=0, dtack_n=1 and go to IDLE.
  - TMO: decrement the counter. At 1, go to ERR.
  - ERR: berr_n=0. Stay until cpu_as_n=1, then set berr_n=1 and go to IDLE.
- Latency:
  - dtack_n falls at cycle W+1 after cycle 0, where W is the region's wait count.
  - berr_n falls at cycle TIMEOUT+1.
  - cs rises at cycle 1.
- Early abort: if cpu_as_n goes to 1 in WAIT or TMO, the next cycle clears cs, returns to IDLE and never asserts dtack_n or berr_n.
- Back-to-back cycles: the IDLE cycle after the release is mandatory. A strobe sampled in that IDLE cycle starts a new access. No cycle is lost.
- cpu_din is combinational from the latched index: dev_dout[idx*DATA_WIDTH +: DATA_WIDTH]. It is all ones when the latched access was a miss or before any access.
- Writes: identical timing. cpu_rw has no effect on the FSM; it is passed to the devices externally.
- Address and data-strobe changes after cycle 0 are ignored until the next IDLE.
- Reset asserted mid-cycle: next edge gives reset values, including RELEASE.

Test Plan:
1. Word read at 0x000010 (region 0, W=0), dev_dout region 0 = 16'hBEEF -> cs=3'b001 at cycle 1, dtack_n=0 at cycle 1, cpu_din=16'hBEEF; deasserting AS gives cs=0 and dtack_n=1 one cycle later.
2. Write at 0x001004 (region 2, W=3), lds only -> cs=3'b100 from cycle 1, dtack_n stays 1 until cycle 4, then 0 until AS is released.
3. Read at 0x004000 (no hit), TIMEOUT=63 -> cs=0, berr_n=0 at cycle 64, cpu_din=16'hFFFF; release AS -> berr_n=1 and the FSM returns to IDLE.
4. Overlap: REGION_BASE region 0 and region 1 both =0, access 0x000000 -> cs=3'b001 only.
5. Abort: region 2 access with AS released at cycle 2 -> dtack_n never 0, cs=0 at cycle 3. Then a region 1 access (W=1) follows: dtack_n=0 at cycle 2 of the new access.
6. Reset: rst pulsed at cycle 2 of a region 2 access with AS still low -> outputs take reset values; no access starts until AS goes high and then falls again.
